// File: rtl/aes128_byte_loader.sv
// Byte-stream front end for aes128_core: assembles 16 input bytes, starts the core, streams the 16-byte result out.
// Optional block counter output blk_cnt_o is enabled by defining AES_LOADER_BLKCNT_EN.
module aes128_byte_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMR_W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [7:0]   in_data_i,
  input  logic         in_dec_i,
  output logic         in_ready_o,
  output logic [127:0] core_text_o,
  output logic         core_start_enc_o,
  output logic         core_start_dec_o,
  input  logic         core_ready_i,
  input  logic         core_done_i,
  input  logic [127:0] core_text_i,
  output logic         out_valid_o,
  output logic [7:0]   out_data_o,
  output logic         out_last_o,
  input  logic         out_ready_i,
  output logic         busy_o,
  output logic         err_o
`ifdef AES_LOADER_BLKCNT_EN
  , output logic [15:0] blk_cnt_o
`endif
);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_e;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       oidx_q;
  logic             dec_q;
  logic [127:0]     text_q;
  logic [127:0]     out_q;
  logic [TMR_W-1:0] tmr_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             start_enc_q;
  logic             start_dec_q;
  logic             out_valid_q;
  logic             err_q;
  logic             in_fire;
  logic             out_fire;
  logic [6:0]       in_bpos;
`ifdef AES_LOADER_BLKCNT_EN
  logic [15:0]      blk_cnt_q;
`endif

  assign in_fire  = in_valid_i && in_ready_q;
  assign out_fire = out_valid_q && out_ready_i;
  // Byte 0 lands in [127:120]: bit offset is 8*(15-cnt).
  assign in_bpos  = {~cnt_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      oidx_q      <= '0;
      dec_q       <= 1'b0;
      text_q      <= '0;
      out_q       <= '0;
      tmr_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef AES_LOADER_BLKCNT_EN
      blk_cnt_q   <= '0;
`endif
    end else begin
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            text_q[in_bpos +: 8] <= in_data_i;
            cnt_q                <= cnt_q + 4'd1;
            if (cnt_q == 4'd0) begin
              dec_q <= in_dec_i;
              err_q <= 1'b0;
            end
            if (cnt_q == 4'd15) begin
              state_q    <= ISSUE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              // Pulse is registered here so it appears the cycle right after byte 15.
              if (core_ready_i) begin
                start_enc_q <= ~dec_q;
                start_dec_q <= dec_q;
              end
            end
          end
        end
        ISSUE: begin
          if (start_enc_q || start_dec_q) begin
            state_q <= WAIT;
            tmr_q   <= '0;
          end else if (core_ready_i) begin
            start_enc_q <= ~dec_q;
            start_dec_q <= dec_q;
          end
        end
        WAIT: begin
          // done has priority over a coincident timeout
          if (core_done_i) begin
            out_q       <= core_text_i;
            out_valid_q <= 1'b1;
            oidx_q      <= '0;
            state_q     <= DRAIN;
          end else if (TIMEOUT_CYCLES != 0 && tmr_q == TMO_LAST) begin
            err_q      <= 1'b1;
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_q  <= {out_q[119:0], 8'h00};
            oidx_q <= oidx_q + 4'd1;
            if (oidx_q == 4'd15) begin
              out_valid_q <= 1'b0;
              state_q     <= LOAD;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
`ifdef AES_LOADER_BLKCNT_EN
              blk_cnt_q   <= blk_cnt_q + 16'd1;
`endif
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready_o       = in_ready_q;
  assign core_text_o      = text_q;
  assign core_start_enc_o = start_enc_q;
  assign core_start_dec_o = start_dec_q;
  assign out_valid_o      = out_valid_q;
  assign out_data_o       = out_q[127:120];
  assign out_last_o       = out_valid_q && (oidx_q == 4'd15);
  assign busy_o           = busy_q;
  assign err_o            = err_q;
`ifdef AES_LOADER_BLKCNT_EN
  assign blk_cnt_o        = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes128_byte_loader.sv
// Directed bench for aes128_byte_loader with a fixed-latency mock core that maps the FIPS-197 vector pair.
module tb_aes128_byte_loader;

  localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_i;
  logic [7:0]   in_data_i;
  logic         in_dec_i;
  logic         in_ready_o;
  logic [127:0] core_text_o;
  logic         core_start_enc_o;
  logic         core_start_dec_o;
  logic         core_ready_i;
  logic         core_done_i;
  logic [127:0] core_text_i;
  logic         out_valid_o;
  logic [7:0]   out_data_o;
  logic         out_last_o;
  logic         out_ready_i;
  logic         busy_o;
  logic         err_o;
`ifdef AES_LOADER_BLKCNT_EN
  logic [15:0]  blk_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // mock core state
  logic         core_hold;
  logic         mock_off;
  int           m_cnt;
  logic [127:0] m_res;
  int           n_enc;
  int           n_dec;

  always #5 clk = ~clk;

  aes128_byte_loader #(.TIMEOUT_CYCLES(20), .TMR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_dec_i(in_dec_i), .in_ready_o(in_ready_o),
    .core_text_o(core_text_o), .core_start_enc_o(core_start_enc_o), .core_start_dec_o(core_start_dec_o),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_text_i(core_text_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .err_o(err_o)
`ifdef AES_LOADER_BLKCNT_EN
    , .blk_cnt_o(blk_cnt_o)
`endif
  );

  assign core_ready_i = !core_hold && (m_cnt == 0);

  // Mock core: 5-cycle latency, only knows the one plaintext/ciphertext pair.
  always @(posedge clk) begin
    core_done_i <= 1'b0;
    if (core_start_enc_o) n_enc <= n_enc + 1;
    if (core_start_dec_o) n_dec <= n_dec + 1;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        core_done_i <= 1'b1;
        core_text_i <= m_res;
      end
    end else if ((core_start_enc_o || core_start_dec_o) && !mock_off) begin
      m_cnt <= 5;
      if (core_start_enc_o && core_text_o == PT)      m_res <= CT;
      else if (core_start_dec_o && core_text_o == CT) m_res <= PT;
      else                                            m_res <= '1;
    end
  end

  task automatic send_block(input logic [127:0] blk, input bit dec, input bit gaps,
                            input int first, input int last);
    for (int i = first; i < last; i++) begin
      int w = 0;
      if (gaps && i[0]) begin
        in_valid_i = 1'b0;
        in_data_i  = 8'hA5;
        @(negedge clk);
      end
      in_valid_i = 1'b1;
      in_data_i  = blk[8*(15-i) +: 8];
      in_dec_i   = (i == 0) ? dec : !dec;
      while (!in_ready_o && w < 200) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(output bit tmo);
    int w = 0;
    while (!core_done_i && w < 100) begin
      @(negedge clk);
      w++;
    end
    tmo = !core_done_i;
  endtask

  task automatic recv_block(input bit bp, output logic [127:0] blk, output int last_bad,
                            output int unstable, output bit tmo);
    int k = 0;
    int cyc = 0;
    int held = 0;
    logic [7:0] hd = 8'h00;
    blk = '0; last_bad = 0; unstable = 0;
    while (k < 16 && cyc < 1000) begin
      if (bp && k == 7 && held < 10) begin
        out_ready_i = 1'b0;
        if (out_valid_o) begin
          if (held == 0) hd = out_data_o;
          else if (out_data_o !== hd || out_last_o !== 1'b0) unstable++;
          held++;
        end
      end else if (bp && k > 7) begin
        out_ready_i = cyc[0];
      end else begin
        out_ready_i = 1'b1;
      end
      if (out_valid_o && out_ready_i) begin
        blk[8*(15-k) +: 8] = out_data_o;
        if (out_last_o !== (k == 15)) last_bad++;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready_i = 1'b1;
    tmo = (k < 16);
  endtask

  task automatic test_reset;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b%b want 00", busy_o, err_o); end
    checks++; if (core_start_enc_o !== 1'b0 || core_start_dec_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b%b want 00", core_start_enc_o, core_start_dec_o); end
    checks++; if (core_text_o !== 128'h0) begin errors++; $display("FAIL reset_text: got %h want 0", core_text_o); end
    checks++; if (out_data_o !== 8'h00 || out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out: got %h/%b want 00/0", out_data_o, out_last_o); end
`ifdef AES_LOADER_BLKCNT_EN
    checks++; if (blk_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt_o); end
`endif
  endtask

  task automatic test_encrypt;
    logic [127:0] r; int lb, us; bit t;
    int e0 = n_enc, d0 = n_dec;
    send_block(PT, 1'b0, 1'b0, 0, 16);
    checks++; if (core_start_enc_o !== 1'b1 || core_start_dec_o !== 1'b0) begin errors++; $display("FAIL enc_start_latency: got enc=%b dec=%b want 1 0", core_start_enc_o, core_start_dec_o); end
    checks++; if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL enc_issue_flags: got rdy=%b busy=%b want 0 1", in_ready_o, busy_o); end
    checks++; if (core_text_o !== PT) begin errors++; $display("FAIL enc_core_text: got %h want %h", core_text_o, PT); end
    wait_done(t);
    checks++; if (t || out_valid_o !== 1'b0) begin errors++; $display("FAIL enc_done_wait: tmo=%b out_valid=%b want 0 0", t, out_valid_o); end
    @(negedge clk);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h39) begin errors++; $display("FAIL enc_first_byte: got %b/%h want 1/39", out_valid_o, out_data_o); end
    recv_block(1'b0, r, lb, us, t);
    checks++; if (r !== CT || t) begin errors++; $display("FAIL enc_result: got %h want %h", r, CT); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL enc_last: got %0d misplaced want 0", lb); end
    checks++; if (n_enc !== e0 + 1 || n_dec !== d0) begin errors++; $display("FAIL enc_pulses: got enc=%0d dec=%0d want 1 0", n_enc - e0, n_dec - d0); end
    checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL enc_back_to_load: got rdy=%b busy=%b want 1 0", in_ready_o, busy_o); end
  endtask

  task automatic test_decrypt;
    logic [127:0] r; int lb, us; bit t;
    int e0 = n_enc, d0 = n_dec;
    send_block(CT, 1'b1, 1'b0, 0, 16);
    checks++; if (core_start_dec_o !== 1'b1 || core_start_enc_o !== 1'b0) begin errors++; $display("FAIL dec_start: got enc=%b dec=%b want 0 1", core_start_enc_o, core_start_dec_o); end
    recv_block(1'b0, r, lb, us, t);
    checks++; if (r !== PT || t) begin errors++; $display("FAIL dec_result: got %h want %h", r, PT); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL dec_last: got %0d misplaced want 0", lb); end
    checks++; if (n_dec !== d0 + 1 || n_enc !== e0) begin errors++; $display("FAIL dec_pulses: got enc=%0d dec=%0d want 0 1", n_enc - e0, n_dec - d0); end
  endtask

  task automatic test_backpressure;
    logic [127:0] r; int lb, us; bit t;
    send_block(PT, 1'b0, 1'b1, 0, 16);
    checks++; if (core_text_o !== PT) begin errors++; $display("FAIL bp_gapped_load: got %h want %h", core_text_o, PT); end
    recv_block(1'b1, r, lb, us, t);
    checks++; if (us !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", us); end
    checks++; if (r !== CT || t) begin errors++; $display("FAIL bp_result: got %h want %h", r, CT); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL bp_last: got %0d misplaced want 0", lb); end
  endtask

  task automatic test_core_not_ready;
    logic [127:0] r; int lb, us; bit t;
    int e0 = n_enc, viol = 0;
    core_hold = 1'b1;
    send_block(PT, 1'b0, 1'b0, 0, 16);
    repeat (50) begin
      if (core_start_enc_o || core_start_dec_o || in_ready_o) viol++;
      @(negedge clk);
    end
    checks++; if (viol !== 0 || n_enc !== e0) begin errors++; $display("FAIL nr_hold: got %0d bad cycles, %0d pulses want 0 0", viol, n_enc - e0); end
    core_hold = 1'b0;
    @(negedge clk);
    checks++; if (core_start_enc_o !== 1'b1) begin errors++; $display("FAIL nr_release_pulse: got %b want 1", core_start_enc_o); end
    @(negedge clk);
    checks++; if (core_start_enc_o !== 1'b0) begin errors++; $display("FAIL nr_single_pulse: got %b want 0", core_start_enc_o); end
    recv_block(1'b0, r, lb, us, t);
    checks++; if (r !== CT || t || n_enc !== e0 + 1) begin errors++; $display("FAIL nr_result: got %h pulses=%0d want %h 1", r, n_enc - e0, CT); end
  endtask

  task automatic test_timeout;
    logic [127:0] r; int lb, us; bit t;
    int ov = 0;
    mock_off = 1'b1;
    send_block(PT, 1'b0, 1'b0, 0, 16);
    checks++; if (core_start_enc_o !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", core_start_enc_o); end
    repeat (20) begin
      @(negedge clk);
      if (out_valid_o) ov++;
    end
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL tmo_early: got err=%b busy=%b want 0 1", err_o, busy_o); end
    @(negedge clk);
    checks++; if (err_o !== 1'b1 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL tmo_fire: got err=%b rdy=%b busy=%b want 1 1 0", err_o, in_ready_o, busy_o); end
    checks++; if (ov !== 0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL tmo_no_output: got %0d valid cycles want 0", ov); end
    mock_off = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", err_o); end
    send_block(PT, 1'b0, 1'b0, 0, 1);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", err_o); end
    send_block(PT, 1'b0, 1'b0, 1, 16);
    recv_block(1'b0, r, lb, us, t);
    checks++; if (r !== CT || t) begin errors++; $display("FAIL tmo_next_block: got %h want %h", r, CT); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] r; int lb, us; bit t;
    send_block(CT, 1'b1, 1'b0, 0, 9);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || core_text_o !== 128'h0) begin errors++; $display("FAIL rst_mid_async: got rdy=%b busy=%b text=%h want 1 0 0", in_ready_o, busy_o, core_text_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_block(PT, 1'b0, 1'b0, 0, 16);
    checks++; if (core_start_enc_o !== 1'b1 || core_text_o !== PT) begin errors++; $display("FAIL rst_mid_block: got enc=%b text=%h want 1 %h", core_start_enc_o, core_text_o, PT); end
    recv_block(1'b0, r, lb, us, t);
    checks++; if (r !== CT || t) begin errors++; $display("FAIL rst_mid_result: got %h want %h", r, CT); end
`ifdef AES_LOADER_BLKCNT_EN
    checks++; if (blk_cnt_o !== 16'd1) begin errors++; $display("FAIL rst_mid_blk_cnt: got %0d want 1", blk_cnt_o); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; in_dec_i = 1'b0; out_ready_i = 1'b1;
    core_hold = 1'b0; mock_off = 1'b0; m_cnt = 0; m_res = '0; n_enc = 0; n_dec = 0;
    core_done_i = 1'b0; core_text_i = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_encrypt;
    test_decrypt;
    test_backpressure;
    test_core_not_ready;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes128_byte_loader.md
Name: aes128_byte_loader

Overview:
- Byte-stream front end for aes128_core.
- Collects a 16-byte block from an 8-bit valid/ready input stream and issues a one-cycle start_enc or start_dec pulse to the core.
- Captures the 128-bit result on the core's done pulse and streams it out as 16 bytes on an 8-bit valid/ready output.
- Sits between the UART/byte transport and aes128_core, replacing the switch/button stimulus used on the board top.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles in WAIT before aborting with err_o; 0 disables the timeout.
- TMR_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  input byte valid
- in_data_i  input  8  input byte
- in_dec_i  input  1  operation select, sampled with byte 0 of a block (0 = encrypt, 1 = decrypt)
- in_ready_o  output  1  loader accepts a byte this cycle
- core_text_o  output  128  assembled block to the core text_i
- core_start_enc_o  output  1  one-cycle encrypt start pulse
- core_start_dec_o  output  1  one-cycle decrypt start pulse
- core_ready_i  input  1  core idle and able to start
- core_done_i  input  1  one-cycle pulse; core_text_i is valid in the same cycle
- core_text_i  input  128  core result
- out_valid_o  output  1  output byte valid
- out_data_o  output  8  output byte
- out_last_o  output  1  high with the 16th output byte
- out_ready_i  input  1  downstream accepts the byte
- busy_o  output  1  high in any state other than LOAD
- err_o  output  1  sticky timeout flag, cleared when the next block's byte 0 is accepted

Behaviour:
- Reset values: all outputs 0, except in_ready_o = 1. State = LOAD, byte count = 0, text register = 0.
- Input transfers when in_valid_i && in_ready_o. Output transfers when out_valid_o && out_ready_i.
- Byte order is big-endian on both streams: byte 0 maps to bits [127:120] and byte 15 to bits [7:0].
- LOAD state:
  - in_ready_o = 1.
  - Each transfer writes the byte into the text register and increments the 4-bit count.
  - in_dec_i is latched on count 0.
  - On the transfer with count 15: count wraps to 0, in_ready_o drops the next cycle, and the state goes to ISSUE.
- ISSUE state:
  - in_ready_o = 0.
  - When core_ready_i = 1, assert exactly one of core_start_enc_o / core_start_dec_o for one cycle, then go to WAIT.
  - While core_ready_i = 0, hold in ISSUE indefinitely and issue no pulse.
- WAIT state:
  - Timeout counter clears on entry and increments every cycle.
  - On core_done_i = 1: capture core_text_i into the output register and go to DRAIN.
  - If the counter reaches TIMEOUT_CYCLES (when nonzero) before done: set err_o, go to LOAD, emit no output.
  - If core_done_i and the timeout occur in the same cycle, done wins.
- DRAIN state:
  - out_valid_o = 1 with out_data_o = the current byte.
  - out_data_o and out_last_o are held stable while out_valid_o = 1 and out_ready_i = 0.
  - Each transfer advances the byte index. The transfer of byte 15 (out_last_o = 1) returns the state to LOAD, and in_ready_o = 1 the next cycle.
- core_text_o is driven from the text register and held stable from ISSUE through WAIT.
- A core_done_i outside WAIT is ignored.
- Latency: the start pulse occurs 1 cycle after the 16th input byte when core_ready_i = 1. The first output byte is valid 1 cycle after core_done_i.
- Reset mid-operation: any state returns immediately to the LOAD reset values. A partial block is discarded and a partial output is dropped.

Optional Feature:
- Macro: AES_LOADER_BLKCNT_EN.
- When defined:
  - Adds output port blk_cnt_o[15:0] (reset 0).
  - The counter increments on each completed DRAIN (last output byte transferred) and wraps from 16'hFFFF to 0.
  - Timed-out blocks are not counted.
- When undefined: the port and counter do not exist, and the rest of the behaviour is unchanged.

Test Plan:
- Encrypt round trip: stream bytes 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34 with in_dec_i = 0 and key 2b7e1516...4f3c in the core -> one core_start_enc_o pulse, then output bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32 with out_last_o on byte 15.
- Decrypt: stream the ciphertext above with in_dec_i = 1 -> core_start_dec_o only, output 3243f6a8...0734.
- Backpressure: hold out_ready_i = 0 for 10 cycles at byte 7, then toggle it -> out_data_o stays stable and no byte is lost or duplicated. Toggle in_valid_i during LOAD -> the block still assembles correctly.
- Core not ready: hold core_ready_i = 0 for 50 cycles after byte 15 -> no start pulse and in_ready_o = 0. Release -> a single pulse on the next cycle.
- Timeout: TIMEOUT_CYCLES = 20 and no core_done_i -> err_o = 1 at cycle 20 of WAIT, in_ready_o = 1, no output. The next block's byte 0 clears err_o.
- Reset mid-LOAD after 9 bytes -> count 0. A fresh 16-byte block then produces the correct result. With AES_LOADER_BLKCNT_EN, blk_cnt_o = 1 after that block.
